glip_out_arbiter: RTL and testbench
===================================

Name: glip_out_arbiter

Overview:
- Shares the single GLIP host-bound FIFO channel (fifo_out, WIDTH bits) between NUM_PORTS on-chip requesters, e.g. several stress-test or debug sources.
- Arbitrates round-robin at packet granularity.
- Prefixes each granted packet with one header word carrying the source port index, so the host can demultiplex.
- Enforces a maximum packet length so that one requester cannot hold the channel forever.

Parameters:
- WIDTH, 16: data width of requester ports and fifo_out; must be ≥ PORT_BITS+1.
- NUM_PORTS, 4: number of requesters, 2..16.
- MAX_LEN, 64: maximum payload beats per grant, ≥1.
- PORT_BITS, $clog2(NUM_PORTS): width of the port index.

Ports:
- clk  in  1  clock, shared by logic and fifo_out.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_PORTS  per-requester beat valid.
- req_data  in  NUM_PORTS*WIDTH  per-requester data; port i occupies bits [i*WIDTH +: WIDTH].
- req_last  in  NUM_PORTS  per-requester end-of-packet, qualified by valid.
- req_ready  out  NUM_PORTS  per-requester beat accept.
- fifo_out_valid  out  1  beat valid toward GLIP.
- fifo_out_data  out  WIDTH  beat data toward GLIP.
- fifo_out_ready  in  1  GLIP accepts the beat.
- grant  out  NUM_PORTS  one-hot owner of the channel; 0 in IDLE.
- trunc  out  1  one-cycle pulse when a packet is cut at MAX_LEN.

Behaviour:
- Handshake: a beat transfers on a cycle where valid && ready are both high. Valid, once asserted, is held with stable data until transfer. The block obeys this on fifo_out and relies on it from requesters.
- State machine has three states: IDLE, HEADER, PAYLOAD.
- Reset (rst low, asynchronous):
  - state=IDLE, grant=0, req_ready=0, fifo_out_valid=0, fifo_out_data=0, trunc=0.
  - rr_ptr = NUM_PORTS-1, so port 0 has first priority.
  - beat_cnt=0.
- IDLE:
  - If any req_valid is high, select the first valid port scanning rr_ptr+1, rr_ptr+2, … modulo NUM_PORTS.
  - Register the selection as sel and go to HEADER.
  - The decision is registered; grant asserts in the cycle after req_valid is first seen.
  - No req_ready is asserted in IDLE.
- HEADER:
  - fifo_out_valid=1.
  - fifo_out_data: MSB=1, bits [PORT_BITS-1:0]=sel, all other bits 0.
  - grant[sel]=1; all req_ready=0.
  - On fifo_out_ready, go to PAYLOAD with beat_cnt=0.
  - The header is stalled indefinitely while fifo_out_ready is low.
- PAYLOAD:
  - Combinational pass-through: fifo_out_valid=req_valid[sel], fifo_out_data=req_data[sel], req_ready[sel]=fifo_out_ready.
  - All other req_ready=0.
  - On each transfer, beat_cnt increments.
  - The beat that ends the grant is either a transfer with req_last[sel]=1, or a transfer with beat_cnt==MAX_LEN-1.
  - On that beat: go to IDLE and set rr_ptr=sel.
  - If the beat ended on MAX_LEN and req_last=0, pulse trunc for one cycle. The remaining beats are later re-arbitrated as a new packet with a new header.
  - Simultaneous last and MAX_LEN counts as a normal end; no trunc.
- A requester dropping req_valid mid-packet just stalls PAYLOAD. The grant is held with no timeout.
- Minimum grant cycle, with fifo_out_ready held high: IDLE, HEADER, one or more PAYLOAD cycles, then IDLE. This gives one idle cycle between packets.
- Changes on non-granted req_* inputs have no effect until the next IDLE.
- Reset asserted mid-packet aborts immediately: the partial packet is lost and no completion is emitted.
- beat_cnt width is $clog2(MAX_LEN+1). It never wraps, because the grant ends at MAX_LEN.

Test Plan:
- Reset, then port 2 sends 3 beats 0x1111, 0x2222, 0x3333 (last on the 3rd), fifo_out_ready=1 → fifo_out carries 0x8002, 0x1111, 0x2222, 0x3333; grant=4'b0100 for 4 cycles; trunc never pulses.
- All 4 ports continuously valid with 1-beat packets (data=0x00i0) → header order 0x8000, 0x8001, 0x8002, 0x8003, 0x8000, …; each header is followed by its own data; no port is starved.
- MAX_LEN=4; port 1 sends 6 beats, last on the 6th → 0x8001 plus 4 beats and trunc pulses once; then 0x8001 plus the remaining 2 beats with no trunc.
- fifo_out_ready toggled randomly 50% during header and payload → fifo_out_valid/data stay stable while stalled; beat counts and order are identical to the ready=1 case.
- Port 0 stalls req_valid for 10 cycles mid-packet while port 3 is valid → grant stays 4'b0001; port 3 is served only after port 0's last beat.
- rst pulsed low in PAYLOAD → outputs go to reset values in the same cycle; after release, port 0 has first priority.

Source files
------------

// File: rtl/glip_out_arbiter.sv
// Round-robin, packet-granular arbiter sharing one GLIP host-bound FIFO between requesters.
// Each granted packet is preceded by a header word carrying the source port index.
module glip_out_arbiter #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned MAX_LEN   = 64,
  parameter int unsigned PORT_BITS = $clog2(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       req_valid,
  input  logic [NUM_PORTS*WIDTH-1:0] req_data,
  input  logic [NUM_PORTS-1:0]       req_last,
  output logic [NUM_PORTS-1:0]       req_ready,
  output logic                       fifo_out_valid,
  output logic [WIDTH-1:0]           fifo_out_data,
  input  logic                       fifo_out_ready,
  output logic [NUM_PORTS-1:0]       grant,
  output logic                       trunc
);

  localparam int unsigned CntW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {StIdle, StHeader, StPayload} state_e;

  state_e                state_q, state_d;
  logic [PORT_BITS-1:0]  sel_q, sel_d;
  logic [PORT_BITS-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]       beat_cnt_q, beat_cnt_d;
  logic                  trunc_q, trunc_d;

  logic                  arb_found;
  logic [PORT_BITS-1:0]  arb_idx;
  logic                  cur_valid;
  logic                  cur_last;
  logic [WIDTH-1:0]      cur_data;
  logic [WIDTH-1:0]      hdr_data;
  logic                  xfer;
  logic                  at_max;

  // First valid port strictly after the last served one, wrapping around.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_PORTS;
      if (!arb_found && req_valid[idx]) begin
        arb_found = 1'b1;
        arb_idx   = PORT_BITS'(idx);
      end
    end
  end

  always_comb begin
    hdr_data                = '0;
    hdr_data[WIDTH-1]       = 1'b1;
    hdr_data[PORT_BITS-1:0] = sel_q;
  end

  assign cur_valid = req_valid[sel_q];
  assign cur_last  = req_last[sel_q];
  assign cur_data  = req_data[32'(sel_q) * WIDTH +: WIDTH];
  assign xfer      = (state_q == StPayload) && cur_valid && fifo_out_ready;
  assign at_max    = (beat_cnt_q == CntW'(MAX_LEN - 1));

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    trunc_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          sel_d   = arb_idx;
          state_d = StHeader;
        end
      end
      StHeader: begin
        if (fifo_out_ready) begin
          beat_cnt_d = '0;
          state_d    = StPayload;
        end
      end
      StPayload: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (cur_last || at_max) begin
            // A cut at MAX_LEN that coincides with last is a normal end.
            trunc_d    = !cur_last;
            beat_cnt_d = '0;
            rr_ptr_d   = sel_q;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      rr_ptr_q   <= PORT_BITS'(NUM_PORTS - 1);
      beat_cnt_q <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      trunc_q    <= trunc_d;
    end
  end

  // Payload is a combinational pass-through of the granted requester.
  always_comb begin
    fifo_out_valid = 1'b0;
    fifo_out_data  = '0;
    req_ready      = '0;
    grant          = '0;
    unique case (state_q)
      StHeader: begin
        fifo_out_valid = 1'b1;
        fifo_out_data  = hdr_data;
        grant[sel_q]   = 1'b1;
      end
      StPayload: begin
        fifo_out_valid   = cur_valid;
        fifo_out_data    = cur_data;
        req_ready[sel_q] = fifo_out_ready;
        grant[sel_q]     = 1'b1;
      end
      default: ;
    endcase
  end

  assign trunc = trunc_q;

endmodule

// File: tb/tb_glip_out_arbiter.sv
// Directed bench for glip_out_arbiter: requester models, output capture and expected streams.
module tb_glip_out_arbiter;

  localparam int NP = 4;
  localparam int W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     req_valid;
  logic [NP*W-1:0]   req_data;
  logic [NP-1:0]     req_last;
  logic [NP-1:0]     req_ready;
  logic              fifo_out_valid;
  logic [W-1:0]      fifo_out_data;
  logic              fifo_out_ready;
  logic [NP-1:0]     grant;
  logic              trunc;

  glip_out_arbiter #(
    .WIDTH    (W),
    .NUM_PORTS(NP),
    .MAX_LEN  (4)
  ) u_dut (
    .clk           (clk),
    .rst           (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .fifo_out_valid(fifo_out_valid),
    .fifo_out_data (fifo_out_data),
    .fifo_out_ready(fifo_out_ready),
    .grant         (grant),
    .trunc         (trunc)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] mem_d [NP][32];
  logic        mem_l [NP][32];
  int          wr_cnt [NP];
  int          rd_ptr [NP];
  int          hold [NP];
  int          stall_idx [NP];
  bit          rdy_rand;
  logic [15:0] out_q [$];
  logic [15:0] exp_q [$];
  int          trunc_cnt;
  int          g2_cnt;
  bit          stalled_prev;
  logic [15:0] prev_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int p, input logic [15:0] d, input logic l);
    mem_d[p][wr_cnt[p]] = d;
    mem_l[p][wr_cnt[p]] = l;
    wr_cnt[p]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      req_valid[i]        = 1'b0;
      req_last[i]         = 1'b0;
      req_data[i*W +: W]  = '0;
      if (stall_idx[i] == rd_ptr[i] && rd_ptr[i] < wr_cnt[i]) begin
        hold[i]      = 10;
        stall_idx[i] = -1;
      end
      if (hold[i] > 0) begin
        hold[i]--;
      end else if (rd_ptr[i] < wr_cnt[i]) begin
        req_valid[i]       = 1'b1;
        req_last[i]        = mem_l[i][rd_ptr[i]];
        req_data[i*W +: W] = mem_d[i][rd_ptr[i]];
      end
    end
    fifo_out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic cycle();
    logic [NP-1:0] xfer;
    @(negedge clk);
    if (stalled_prev) begin
      check_eq("stable_valid", 32'(fifo_out_valid), 32'd1);
      check_eq("stable_data", 32'(fifo_out_data), 32'(prev_data));
    end
    stalled_prev = fifo_out_valid && !fifo_out_ready;
    prev_data    = fifo_out_data;
    if (fifo_out_valid && fifo_out_ready) out_q.push_back(fifo_out_data);
    if (trunc) trunc_cnt++;
    if (grant == 4'b0100) g2_cnt++;
    xfer = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) if (xfer[i]) rd_ptr[i]++;
    drive();
  endtask

  function automatic bit all_done();
    all_done = 1'b1;
    for (int i = 0; i < NP; i++) if (rd_ptr[i] < wr_cnt[i]) all_done = 1'b0;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < NP; i++) begin
      wr_cnt[i]    = 0;
      rd_ptr[i]    = 0;
      hold[i]      = 0;
      stall_idx[i] = -1;
    end
    out_q.delete();
    exp_q.delete();
    trunc_cnt    = 0;
    g2_cnt       = 0;
    stalled_prev = 1'b0;
  endtask

  task automatic do_reset();
    clear_all();
    rst_n = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_idle();
    int n;
    n = 0;
    drive();
    while (n < 400 && !(all_done() && grant == '0 && !fifo_out_valid)) begin
      cycle();
      n++;
    end
    check_eq("drain_timeout", 32'(n < 400), 32'd1);
    cycle();
    cycle();
  endtask

  task automatic check_out();
    check_eq("out_len", 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("out[%0d]", i), 32'(out_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    rdy_rand = 1'b0;
    clear_all();
    drive();
    @(negedge clk);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_valid", 32'(fifo_out_valid), 32'd0);
    check_eq("rst_data", 32'(fifo_out_data), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_trunc", 32'(trunc), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single 3-beat packet from port 2.
    push(2, 16'h1111, 1'b0);
    push(2, 16'h2222, 1'b0);
    push(2, 16'h3333, 1'b1);
    run_idle();
    exp_q = '{16'h8002, 16'h1111, 16'h2222, 16'h3333};
    check_out();
    check_eq("t1_grant_cycles", 32'(g2_cnt), 32'd4);
    check_eq("t1_trunc", 32'(trunc_cnt), 32'd0);

    // All ports valid, 1-beat packets: round-robin order.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) push(p, 16'(p << 4), 1'b1);
    run_idle();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) begin
        exp_q.push_back(16'h8000 | 16'(p));
        exp_q.push_back(16'(p << 4));
      end
    check_out();
    check_eq("t2_trunc", 32'(trunc_cnt), 32'd0);

    // 6-beat packet against MAX_LEN=4: cut, then re-arbitrated remainder.
    do_reset();
    for (int b = 1; b <= 6; b++) push(1, 16'hA000 | 16'(b), 1'(b == 6));
    run_idle();
    exp_q = '{16'h8001, 16'hA001, 16'hA002, 16'hA003, 16'hA004,
              16'h8001, 16'hA005, 16'hA006};
    check_out();
    check_eq("t3_trunc", 32'(trunc_cnt), 32'd1);

    // Random back-pressure: same stream as the ready=1 case.
    do_reset();
    rdy_rand = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) push(p, 16'(p << 4), 1'b1);
    run_idle();
    rdy_rand = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) begin
        exp_q.push_back(16'h8000 | 16'(p));
        exp_q.push_back(16'(p << 4));
      end
    check_out();
    check_eq("t4_trunc", 32'(trunc_cnt), 32'd0);

    // Port 0 stalls mid-packet while port 3 waits; 4 beats = last at MAX_LEN.
    do_reset();
    for (int b = 0; b < 4; b++) push(0, 16'hB000 | 16'(b), 1'(b == 3));
    push(3, 16'hC000, 1'b1);
    stall_idx[0] = 2;
    drive();
    n = 0;
    while (rd_ptr[0] < 2 && n < 100) begin
      cycle();
      n++;
    end
    check_eq("t5_reach_timeout", 32'(n < 100), 32'd1);
    repeat (10) begin
      cycle();
      check_eq("t5_grant_hold", 32'(grant), 32'd1);
    end
    run_idle();
    exp_q = '{16'h8000, 16'hB000, 16'hB001, 16'hB002, 16'hB003, 16'h8003, 16'hC000};
    check_out();
    check_eq("t5_trunc", 32'(trunc_cnt), 32'd0);

    // Reset asserted in PAYLOAD.
    do_reset();
    for (int b = 0; b < 4; b++) push(1, 16'hD000 | 16'(b), 1'(b == 3));
    drive();
    n = 0;
    while (out_q.size() < 2 && n < 100) begin
      cycle();
      n++;
    end
    check_eq("t6_reach_timeout", 32'(n < 100), 32'd1);
    check_eq("t6_pre_grant", 32'(grant), 32'b0010);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_grant", 32'(grant), 32'd0);
    check_eq("t6_rst_valid", 32'(fifo_out_valid), 32'd0);
    check_eq("t6_rst_data", 32'(fifo_out_data), 32'd0);
    check_eq("t6_rst_ready", 32'(req_ready), 32'd0);
    clear_all();
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;
    push(2, 16'hE002, 1'b1);
    push(0, 16'hE000, 1'b1);
    run_idle();
    exp_q = '{16'h8000, 16'hE000, 16'h8002, 16'hE002};
    check_out();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
